// File: rtl/mem_defines.sv
// Shared memory-subsystem definitions: SDRAM word/address types, physical
// memory limits and the cache-line transfer types used by the line bridge.
package mem_defines;

  localparam logic [31:0] MAX_PHY_MEM      = 32'h01ff_ffff;
  localparam logic [31:0] MMIO_BASE        = 32'h0200_0000;
  localparam int          sdram_access_len = 8;
  localparam int          LINE_BYTES       = 16;

  typedef logic [23:0]       sdram_addr_t;
  typedef logic [15:0]       sdram_wd_t;
  typedef sdram_wd_t [7:0]   sdram_8_wd_t;
  typedef logic [127:0]      line128_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WR_DATA,
    RD_DATA,
    RESP
  } line_xfer_state_t;

endpackage

// File: rtl/sdram_line_bridge.sv
// Bridges 128-bit cache line fills/writebacks onto a 16-bit SDRAM burst
// interface. One transfer in flight at a time; out-of-range addresses are
// answered with an error without touching the SDRAM.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | ready for a request; captures direction, address and line
// ISSUE   | burst request held on sdram_req until sdram_ack
// WR_DATA | streaming line words out, one per sdram_wr_pull
// RD_DATA | collecting line words, one per sdram_rd_valid
// RESP    | single-cycle response pulse, then back to IDLE
module sdram_line_bridge
  import mem_defines::*;
#(
  parameter logic [31:0] ADDR_LIMIT = MAX_PHY_MEM,
  parameter int          BURST_LEN  = sdram_access_len
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [31:0]  req_addr,
  input  logic [127:0] req_line,
  output logic         resp_valid,
  output logic         resp_err,
  output logic [127:0] resp_line,
  output logic         sdram_req,
  output logic         sdram_we,
  output logic [23:0]  sdram_addr,
  input  logic         sdram_ack,
  input  logic         sdram_wr_pull,
  output logic [15:0]  sdram_wdata,
  input  logic         sdram_rd_valid,
  input  logic [15:0]  sdram_rdata
);

  localparam logic [2:0] LAST_CNT = 3'(BURST_LEN - 1);

  line_xfer_state_t state, state_nxt;
  logic [2:0]       cnt;
  logic             we_q;
  logic             err_q;
  sdram_addr_t      addr_q;
  sdram_8_wd_t      words;
  line128_t         line_q;
  line128_t         fill_line;
  logic             in_range;

  assign in_range   = (req_addr <= ADDR_LIMIT);
  assign sdram_we   = we_q;
  assign sdram_addr = addr_q;
  assign resp_line  = line_q;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    sdram_req   = 1'b0;
    sdram_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = in_range ? ISSUE : RESP;
      end
      ISSUE: begin
        sdram_req = 1'b1;
        if (sdram_ack) state_nxt = we_q ? WR_DATA : RD_DATA;
      end
      WR_DATA: begin
        sdram_wdata = words[cnt];
        if (sdram_wr_pull && cnt == LAST_CNT) state_nxt = RESP;
      end
      RD_DATA: begin
        if (sdram_rd_valid && cnt == LAST_CNT) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Completed line as it will look once the current read beat lands,
  // so resp_line is already valid in the RESP cycle
  always_comb begin
    fill_line = '0;
    for (int k = 0; k < 8; k++) begin
      fill_line[127-16*k -: 16] = (cnt == 3'(k)) ? sdram_rdata : words[k];
    end
  end

  // Request capture, beat counter and line assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
      addr_q <= '0;
      words  <= '0;
      line_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q   <= req_write;
        err_q  <= ~in_range;
        addr_q <= {req_addr[24:4], 3'b000};
        cnt    <= '0;
        for (int k = 0; k < 8; k++) begin
          words[k] <= req_line[127-16*k -: 16];
        end
      end
      if (state == WR_DATA && sdram_wr_pull) begin
        cnt <= cnt + 3'd1;
      end
      if (state == RD_DATA && sdram_rd_valid) begin
        words[cnt] <= sdram_rdata;
        cnt        <= cnt + 3'd1;
        if (cnt == LAST_CNT) line_q <= fill_line;
      end
    end
  end

endmodule

// File: tb/tb_sdram_line_bridge.sv
// Randomized self-checking bench for sdram_line_bridge. The bench plays the
// cache and the SDRAM controller; a queue of expected responses plus a
// "last completed fill" line form the reference model.
module tb_sdram_line_bridge;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_line = '0;
  logic         resp_valid;
  logic         resp_err;
  logic [127:0] resp_line;
  logic         sdram_req;
  logic         sdram_we;
  logic [23:0]  sdram_addr;
  logic         sdram_ack = 1'b0;
  logic         sdram_wr_pull = 1'b0;
  logic [15:0]  sdram_wdata;
  logic         sdram_rd_valid = 1'b0;
  logic [15:0]  sdram_rdata = '0;

  sdram_line_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_line(req_line),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
    .sdram_req(sdram_req), .sdram_we(sdram_we), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_wr_pull(sdram_wr_pull), .sdram_wdata(sdram_wdata),
    .sdram_rd_valid(sdram_rd_valid), .sdram_rdata(sdram_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         err;
    logic         write;
    logic [127:0] line;
  } exp_t;

  exp_t         exp_q[$];
  logic         busy = 1'b0;
  logic         busy_clr = 1'b0;
  logic [127:0] shown_line = '0;
  logic [23:0]  seen_addr = '0;
  logic         seen_we = 1'b0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endfunction

  // Model of when the bridge is occupied: from an offered request while free
  // until the response has been seen.
  always @(posedge clk) begin
    if (rst) begin
      busy     = 1'b0;
      busy_clr = 1'b0;
    end else if (busy_clr) begin
      busy     = 1'b0;
      busy_clr = 1'b0;
    end else if (req_valid && !busy) begin
      busy = 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      shown_line = '0;
    end else begin
      chk("req_ready", req_ready, !busy);
      if (resp_valid) begin
        busy_clr = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", resp_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_err", resp_err, e.err);
          if (!e.write && !e.err) shown_line = e.line;
        end
      end
      chk("resp_line", resp_line, shown_line);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_req_ready",  req_ready,   1'b1);
    chk("rst_resp_valid", resp_valid,  1'b0);
    chk("rst_resp_err",   resp_err,    1'b0);
    chk("rst_sdram_req",  sdram_req,   1'b0);
    chk("rst_sdram_we",   sdram_we,    1'b0);
    chk("rst_sdram_addr", sdram_addr,  24'h0);
    chk("rst_wdata",      sdram_wdata, 16'h0);
    chk("rst_resp_line",  resp_line,   128'h0);
  endtask

  task automatic idle_noise(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      sdram_wr_pull  = 1'b1;
      sdram_rd_valid = 1'b1;
      sdram_rdata    = 16'($urandom);
      @(negedge clk);
      chk("noise_no_resp", resp_valid, 1'b0);
    end
    @(posedge clk); #1;
    sdram_wr_pull  = 1'b0;
    sdram_rd_valid = 1'b0;
  endtask

  // mode: 0 = strobe every cycle, 1 = alternate cycles, 2 = random gaps with
  // stray opposite-direction strobes. abort_at != 0 resets after that many words.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [127:0] data,
                      input int ack_dly, input int mode, input int abort_at);
    logic        want_err;
    logic [23:0] want_addr;
    exp_t        e;
    int          n;
    int          cyc;
    int          gap;
    bit          got;
    bit          strobe;

    want_err  = (addr > 32'h01ff_ffff);
    want_addr = 24'((addr >> 1) & 32'h00ff_fff8);

    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_line  = wr ? data : ~data;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (req_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!got) begin
      chk("handshake", got, 1'b1);
      return;
    end
    e.err = want_err; e.write = wr; e.line = data;
    exp_q.push_back(e);

    if (want_err) begin
      @(negedge clk);
      chk("err_resp_timing", resp_valid, 1'b1);
      chk("err_no_sdram_req", sdram_req, 1'b0);
      return;
    end

    for (int i = 0; i < ack_dly; i++) begin
      if (mode == 2) begin
        sdram_wr_pull  = 1'($urandom);
        sdram_rd_valid = 1'($urandom);
        sdram_rdata    = 16'($urandom);
      end
      @(negedge clk);
      chk("issue_req", sdram_req, 1'b1);
      chk("issue_no_resp", resp_valid, 1'b0);
      @(posedge clk); #1;
    end
    sdram_wr_pull  = 1'b0;
    sdram_rd_valid = 1'b0;
    sdram_ack      = 1'b1;
    @(negedge clk);
    chk("issue_req", sdram_req, 1'b1);
    chk("issue_addr", sdram_addr, want_addr);
    chk("issue_we", sdram_we, wr);
    seen_addr = sdram_addr;
    seen_we   = sdram_we;
    @(posedge clk); #1;
    sdram_ack = 1'b0;

    n = 0; cyc = 0; gap = 0;
    while (n < 8) begin
      case (mode)
        0:       strobe = 1'b1;
        1:       strobe = (cyc % 2) == 0;
        default: strobe = ($urandom_range(0, 1) == 1) || (gap >= 3);
      endcase
      if (strobe) begin
        gap = 0;
        if (wr) sdram_wr_pull = 1'b1;
        else begin
          sdram_rd_valid = 1'b1;
          sdram_rdata    = data[127-16*n -: 16];
        end
      end else begin
        gap++;
        if (mode == 2) begin
          if (wr) begin
            sdram_rd_valid = 1'($urandom);
            sdram_rdata    = 16'($urandom);
          end else begin
            sdram_wr_pull = 1'($urandom);
          end
        end
      end
      @(negedge clk);
      chk("data_no_req", sdram_req, 1'b0);
      chk("data_no_resp", resp_valid, 1'b0);
      chk("data_addr_stable", sdram_addr, want_addr);
      chk("data_we_stable", sdram_we, wr);
      if (strobe && wr) chk("wdata", sdram_wdata, data[127-16*n -: 16]);
      @(posedge clk); #1;
      sdram_wr_pull  = 1'b0;
      sdram_rd_valid = 1'b0;
      if (strobe) n++;
      cyc++;
      if (abort_at != 0 && n == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    chk("resp_timing", resp_valid, 1'b1);
    chk("resp_addr_stable", sdram_addr, want_addr);
    chk("resp_we_stable", sdram_we, wr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          sel;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    // writeback, ack after 3 cycles, pull every cycle
    xfer(1'b1, 32'h0000_1230, 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, 3, 0, 0);
    chk("wb_addr_literal", seen_addr, 24'h000918);
    chk("wb_we_literal", seen_we, 1'b1);

    // fill at the top of memory, rd_valid on alternate cycles
    xfer(1'b0, 32'h01ff_fff4, 128'h0001_0002_0003_0004_0005_0006_0007_0008, 0, 1, 0);
    chk("fill_addr_literal", seen_addr, 24'hfffff8);
    chk("fill_we_literal", seen_we, 1'b0);
    chk("fill_line_literal", resp_line, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    // out of range, then last legal line
    xfer(1'b0, 32'h0200_0000, 128'hdead_beef_0000_0000_1111_2222_3333_4444, 0, 0, 0);
    xfer(1'b1, 32'h01ff_fff0, {$urandom, $urandom, $urandom, $urandom}, 1, 2, 0);
    chk("last_line_addr_literal", seen_addr, 24'hfffff8);

    // stray strobes while idle must not disturb anything
    idle_noise(6);
    chk("noise_line_literal", resp_line, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    // reset after 4 of 8 words, then a clean fill
    xfer(1'b0, 32'h0000_4000, {$urandom, $urandom, $urandom, $urandom}, 2, 0, 4);
    xfer(1'b0, 32'h0000_4000, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 1, 0, 0);
    chk("post_abort_line_literal", resp_line, 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321);

    // back-to-back writeback then fill
    xfer(1'b1, 32'h0100_0080, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);
    xfer(1'b0, 32'h0000_00a0, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0);

    repeat (40) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 32'h0200_0000 + 32'($urandom_range(0, 255));
      else if (sel == 1) a = 32'hffff_fff0 | 32'($urandom_range(0, 15));
      else if (sel == 2) a = 32'h01ff_fff0 | 32'($urandom_range(0, 15));
      else               a = $urandom & 32'h01ff_ffff;
      xfer(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom},
           $urandom_range(0, 4), $urandom_range(0, 2), 0);
      if ($urandom_range(0, 2) == 0) idle_noise($urandom_range(1, 4));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdram_line_bridge.md
SDRAM_LINE_BRIDGE -- requirements
Module: sdram_line_bridge

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default MAX_PHY_MEM (32'h01ff_ffff): highest legal byte address.
REQ-002 SHALL have parameter BURST_LEN, default sdram_access_len (8): 16-bit words per line transfer.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  cache requests a line transfer.
REQ-006 req_ready  out  1  bridge accepts a request; transfer happens when req_valid and req_ready are both high.
REQ-007 req_write  in  1  1 = writeback (cache to SDRAM), 0 = fill (SDRAM to cache).
REQ-008 req_addr  in  32  byte address; bits [3:0] ignored.
REQ-009 req_line  in  128  writeback data {w0,w1,w2,w3}, 32-bit words.
REQ-010 resp_valid  out  1  one-cycle pulse: transfer finished.
REQ-011 resp_err  out  1  valid with resp_valid: address out of range.
REQ-012 resp_line  out  128  fill data; valid with resp_valid when req_write was 0.
REQ-013 sdram_req  out  1  burst request, held until sdram_ack.
REQ-014 sdram_we  out  1  burst direction, stable while sdram_req is high.
REQ-015 sdram_addr  out  24  sdram_addr_t word address, = req_addr[24:1] with bits [2:0] forced to 0.
REQ-016 sdram_ack  in  1  controller accepted the burst.
REQ-017 sdram_wr_pull  in  1  controller consumes sdram_wdata this cycle.
REQ-018 sdram_wdata  out  16  current outgoing word.
REQ-019 sdram_rd_valid  in  1  sdram_rdata carries the next word.
REQ-020 sdram_rdata  in  16  incoming word.

Function
REQ-021 Word order: SDRAM word k = line bits [127-16k -: 16] (k=0..7); word 0 is the upper half of line w0, consistent with be_w0.
REQ-022 FSM states SHALL be IDLE, ISSUE, WR_DATA, RD_DATA, RESP.
REQ-023 req_ready = 1 only in IDLE.
REQ-024 IDLE on handshake: capture req_write, address and line.
  - req_addr > ADDR_LIMIT: go to RESP with err=1; no SDRAM access.
  - Otherwise: go to ISSUE.
REQ-025 ISSUE: assert sdram_req and sdram_we = captured req_write. On sdram_ack, deassert sdram_req next cycle; go to WR_DATA (write) or RD_DATA (read).
REQ-026 WR_DATA: sdram_wdata = word[cnt], where cnt is a 3-bit counter reset to 0 on entry.
  - Each sdram_wr_pull: cnt increments.
  - Pull at cnt = BURST_LEN-1: go to RESP.
REQ-027 RD_DATA: each sdram_rd_valid writes sdram_rdata into word[cnt] and increments cnt.
  - The 8th word: go to RESP.
  - sdram_rd_valid outside RD_DATA SHALL be ignored.
REQ-028 sdram_wr_pull outside WR_DATA SHALL be ignored.
REQ-029 RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
  - resp_line holds the assembled line and stays stable until the next accepted fill.
REQ-030 Minimum latency, request acceptance to resp_valid: 1 (ISSUE) + ack wait + 8 data beats + 1 (RESP); for an error, resp_valid comes in the cycle after acceptance.
REQ-031 sdram_addr and sdram_we SHALL remain stable from ISSUE until RESP.
REQ-032 No new request is accepted before resp_valid; back-to-back requests are allowed (req_ready returns to 1 in the cycle after RESP).
REQ-033 Address 0x01ff_fff0 is legal (last line); 0x0200_0000 (MMIO_BASE) returns err.

Reset
REQ-034 On rst: state = IDLE, cnt = 0, resp_line = 0, captured registers = 0.
REQ-035 Reset values of outputs: req_ready=1, resp_valid=0, resp_err=0, sdram_req=0, sdram_we=0, sdram_addr=0, sdram_wdata=0.
REQ-036 Reset during any burst SHALL abort it immediately; no resp_valid is produced for the aborted request.

Structure
REQ-037 Add to mem_defines: line_xfer_state_t enum, typedef line128_t (logic[127:0]), constant LINE_BYTES=16.
REQ-038 Reuse the existing package types sdram_addr_t, sdram_wd_t and sdram_8_wd_t.
REQ-039 Single module, no sub-modules; the line register is an 8-entry sdram_wd_t array indexed by cnt.

Verification
REQ-040 Writeback: addr 0x0000_1230, line 128'h0011_2233_4455_6677_8899_aabb_ccdd_eeff, ack after 3 cycles, pull every cycle -> sdram_addr 24'h000918, sdram_we=1, wdata sequence 0011,2233,...,eeff, then one resp_valid with err=0.
REQ-041 Fill: addr 0x01ff_fff4, rd_valid on alternate cycles with rdata 1,2,...,8 -> sdram_addr 24'hfffff8, resp_line 128'h0001_0002_..._0008.
REQ-042 Out of range: addr 0x0200_0000 -> resp_valid with resp_err=1 one cycle after acceptance, sdram_req never asserted.
REQ-043 Spurious strobes: sdram_rd_valid and sdram_wr_pull pulses while IDLE -> no state change, resp_line unchanged.
REQ-044 Reset mid-burst: assert rst after 4 of 8 words -> all outputs at reset values; a following fill completes correctly.
REQ-045 Back-to-back: writeback immediately followed by a fill -> req_ready low throughout the first transfer, both responses correct, in order.
